// File: rtl/ras_ckpt.sv
// Circular return-address stack with checkpoint/restore for the frontend
// branch predictor. Pushing onto a full stack overwrites the oldest entry.
// The top entry and a checkpoint word {tos, cnt, top} are presented every
// cycle, and a saved checkpoint can be loaded back after a mispredict.
module ras_ckpt #(
   parameter  int DEPTH  = 8,
   parameter  int VLEN   = 39,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int CKPT_W = PTR_W + CNT_W + VLEN
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [VLEN-1:0]   data_i,
   input  logic              restore_i,
   input  logic [CKPT_W-1:0] restore_ckpt_i,
   output logic              top_valid_o,
   output logic [VLEN-1:0]   top_ra_o,
   output logic [CKPT_W-1:0] ckpt_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [VLEN-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0] tos_r;
   logic [CNT_W-1:0] cnt_r;

   logic [PTR_W-1:0] tos_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             wr_en_s;
   logic [PTR_W-1:0] wr_idx_s;
   logic [VLEN-1:0]  wr_data_s;
   logic             overflow_s;
   logic             underflow_s;
   logic             empty_s;

   logic [PTR_W-1:0] rs_tos_s;
   logic [CNT_W-1:0] rs_cnt_s;
   logic [VLEN-1:0]  rs_ra_s;

   assign rs_tos_s = restore_ckpt_i[CKPT_W-1 -: PTR_W];
   assign rs_cnt_s = restore_ckpt_i[VLEN +: CNT_W];
   assign rs_ra_s  = restore_ckpt_i[VLEN-1:0];
   assign empty_s  = (cnt_r == {CNT_W{1'b0}});

   // Next-state decode: reset > flush > restore > push/pop; losers are dropped.
   always_comb begin
      tos_nxt_s   = tos_r;
      cnt_nxt_s   = cnt_r;
      wr_en_s     = 1'b0;
      wr_idx_s    = tos_r;
      wr_data_s   = data_i;
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
      if (rst_i) begin
         wr_en_s = 1'b0;
      end else if (flush_i) begin
         tos_nxt_s = {PTR_W{1'b0}};
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (restore_i) begin
         // Rewrite the top slot, which a wrong-path push/replace may have clobbered
         tos_nxt_s = rs_tos_s;
         cnt_nxt_s = rs_cnt_s;
         wr_en_s   = 1'b1;
         wr_idx_s  = rs_tos_s;
         wr_data_s = rs_ra_s;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               tos_nxt_s = tos_r + PTR_ONE;
               wr_en_s   = 1'b1;
               wr_idx_s  = tos_r + PTR_ONE;
               if (cnt_r == CNT_FULL) begin
                  overflow_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            2'b01: begin
               if (empty_s) begin
                  underflow_s = 1'b1;
               end else begin
                  tos_nxt_s = tos_r - PTR_ONE;
                  cnt_nxt_s = cnt_r - CNT_ONE;
               end
            end
            2'b11: begin
               wr_en_s = 1'b1;
               if (empty_s) begin
                  // Nothing to replace: acts as a plain push onto an empty stack
                  tos_nxt_s = tos_r + PTR_ONE;
                  wr_idx_s  = tos_r + PTR_ONE;
                  cnt_nxt_s = CNT_ONE;
               end else begin
                  wr_idx_s = tos_r;
               end
            end
            default: begin
               wr_en_s = 1'b0;
            end
         endcase
      end
   end

   // Pointer, occupancy and entry storage update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tos_r <= {PTR_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {VLEN{1'b0}};
         end
      end else begin
         tos_r <= tos_nxt_s;
         cnt_r <= cnt_nxt_s;
         if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
         end
      end
   end

   assign top_valid_o = ~empty_s;
   assign top_ra_o    = empty_s ? {VLEN{1'b0}} : mem_r[tos_r];
   assign ckpt_o      = {tos_r, cnt_r, mem_r[tos_r]};
   assign overflow_o  = overflow_s;
   assign underflow_o = underflow_s;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt (DEPTH=4, VLEN=39): vector table,
// hand-written checkpoint/priority sequences and a random run against a
// queue-based stack model.
module tb_ras_ckpt;

   localparam int DEPTH  = 4;
   localparam int VLEN   = 39;
   localparam int PTR_W  = 2;
   localparam int CNT_W  = 3;
   localparam int CKPT_W = PTR_W + CNT_W + VLEN;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic [VLEN-1:0]   data = '0;
   logic              restore = 1'b0;
   logic [CKPT_W-1:0] rckpt = '0;
   logic              top_valid;
   logic [VLEN-1:0]   top_ra;
   logic [CKPT_W-1:0] ckpt;
   logic              ovf;
   logic              unf;

   int n_pass = 0;
   int n_total = 0;

   ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
      .data_i(data), .restore_i(restore), .restore_ckpt_i(rckpt),
      .top_valid_o(top_valid), .top_ra_o(top_ra), .ckpt_o(ckpt),
      .overflow_o(ovf), .underflow_o(unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            flush;
      logic            push;
      logic            pop;
      logic [VLEN-1:0] data;
      logic            exp_valid;
      logic [VLEN-1:0] exp_ra;
      logic [2:0]      exp_cnt;
      logic            exp_ovf;
      logic            exp_unf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // One clock: drive at negedge, check flags mid-cycle, return #1 after posedge.
   task automatic step(input logic r, input logic f, input logic rs, input logic pu,
                       input logic po, input logic [VLEN-1:0] d,
                       input logic [CKPT_W-1:0] ck, input logic e_ovf,
                       input logic e_unf, input string nm);
      @(negedge clk);
      rst = r; flush = f; restore = rs; push = pu; pop = po; data = d; rckpt = ck;
      #1;
      chk({nm, ".ovf"}, 64'(ovf), 64'(e_ovf));
      chk({nm, ".unf"}, 64'(unf), 64'(e_unf));
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; restore = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic chk_top(input string nm, input logic v, input logic [VLEN-1:0] ra,
                          input logic [2:0] c);
      chk({nm, ".valid"}, 64'(top_valid), 64'(v));
      chk({nm, ".ra"}, 64'(top_ra), 64'(ra));
      chk({nm, ".cnt"}, 64'(ckpt[VLEN +: CNT_W]), 64'(c));
   endtask

   function automatic vec_t mk(input logic f, input logic pu, input logic po,
                               input logic [VLEN-1:0] d, input logic v,
                               input logic [VLEN-1:0] ra, input logic [2:0] c,
                               input logic o, input logic u);
      vec_t t;
      t.flush = f; t.push = pu; t.pop = po; t.data = d;
      t.exp_valid = v; t.exp_ra = ra; t.exp_cnt = c; t.exp_ovf = o; t.exp_unf = u;
      return t;
   endfunction

   logic [CKPT_W-1:0] saved;
   logic [VLEN-1:0]   q[$];

   initial begin
      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 39'h0, '0, 1'b0, 1'b0, "reset");
      chk_top("reset", 1'b0, 39'h0, 3'd0);
      chk("reset.ckpt", 64'(ckpt), 64'h0);

      // Scenario 1: fill, then drain past empty
      tbl.push_back(mk(0,1,0,39'h10, 1,39'h10,3'd1,0,0));
      tbl.push_back(mk(0,1,0,39'h20, 1,39'h20,3'd2,0,0));
      tbl.push_back(mk(0,1,0,39'h30, 1,39'h30,3'd3,0,0));
      tbl.push_back(mk(0,1,0,39'h40, 1,39'h40,3'd4,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h30,3'd3,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h20,3'd2,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h10,3'd1,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  0,39'h0, 3'd0,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  0,39'h0, 3'd0,0,1));
      // Scenario 2: overflow on 5th push
      tbl.push_back(mk(0,1,0,39'h10, 1,39'h10,3'd1,0,0));
      tbl.push_back(mk(0,1,0,39'h20, 1,39'h20,3'd2,0,0));
      tbl.push_back(mk(0,1,0,39'h30, 1,39'h30,3'd3,0,0));
      tbl.push_back(mk(0,1,0,39'h40, 1,39'h40,3'd4,0,0));
      tbl.push_back(mk(0,1,0,39'h50, 1,39'h50,3'd4,1,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h40,3'd3,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h30,3'd2,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h20,3'd1,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  0,39'h0, 3'd0,0,0));
      // Scenario 3: replace-top
      tbl.push_back(mk(0,1,0,39'h10, 1,39'h10,3'd1,0,0));
      tbl.push_back(mk(0,1,0,39'h20, 1,39'h20,3'd2,0,0));
      tbl.push_back(mk(0,1,1,39'h99, 1,39'h99,3'd2,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  1,39'h10,3'd1,0,0));
      tbl.push_back(mk(0,0,1,39'h0,  0,39'h0, 3'd0,0,0));
      // push+pop on empty acts as push; flush beats push
      tbl.push_back(mk(0,1,1,39'h55, 1,39'h55,3'd1,0,0));
      tbl.push_back(mk(1,1,0,39'h66, 0,39'h0, 3'd0,0,0));
      tbl.push_back(mk(0,1,0,39'h77, 1,39'h77,3'd1,0,0));

      foreach (tbl[i]) begin
         step(1'b0, tbl[i].flush, 1'b0, tbl[i].push, tbl[i].pop, tbl[i].data, '0,
              tbl[i].exp_ovf, tbl[i].exp_unf, $sformatf("vec%0d", i));
         chk_top($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_ra, tbl[i].exp_cnt);
      end

      // Scenario 4: checkpoint, wrong-path clobber, restore
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 39'h0, '0, 1'b0, 1'b0, "s4.rst");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 39'h100, '0, 1'b0, 1'b0, "s4.p1");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 39'h200, '0, 1'b0, 1'b0, "s4.p2");
      saved = ckpt;
      chk("s4.ckpt", 64'(saved), 64'({2'd2, 3'd2, 39'h200}));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 39'h0, '0, 1'b0, 1'b0, "s4.pop");
      chk_top("s4.pop", 1'b1, 39'h100, 3'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 39'h300, '0, 1'b0, 1'b0, "s4.wp");
      chk_top("s4.wp", 1'b1, 39'h300, 3'd2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 39'h0, saved, 1'b0, 1'b0, "s4.rs");
      chk_top("s4.rs", 1'b1, 39'h200, 3'd2);
      chk("s4.rs.ckpt", 64'(ckpt), 64'({2'd2, 3'd2, 39'h200}));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 39'h0, '0, 1'b0, 1'b0, "s4.pop2");
      chk_top("s4.pop2", 1'b1, 39'h100, 3'd1);

      // Scenario 5: restore beats push; restore beats pop-underflow
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 39'h400, '0, 1'b0, 1'b0, "s5.wp");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 39'h777, saved, 1'b0, 1'b0, "s5.rspush");
      chk_top("s5.rspush", 1'b1, 39'h200, 3'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 39'h0, '0, 1'b0, 1'b0, "s5.pop");
      chk_top("s5.pop", 1'b1, 39'h100, 3'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 39'h5, '0, 1'b0, 1'b0, "s5.flpush");
      chk_top("s5.flpush", 1'b0, 39'h0, 3'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h0, saved, 1'b0, 1'b0, "s5.rspop");
      chk_top("s5.rspop", 1'b1, 39'h200, 3'd2);

      // Scenario 6: reset beats everything
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 39'hA1, '0, 1'b0, 1'b0, "s6.p");
      chk_top("s6.p", 1'b1, 39'hA1, 3'd3);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 39'hBB, saved, 1'b0, 1'b0, "s6.rst");
      chk_top("s6.rst", 1'b0, 39'h0, 3'd0);
      chk("s6.ckpt", 64'(ckpt), 64'h0);

      // Random run against a queue model (back = top, front = oldest)
      q.delete();
      for (int n = 0; n < 400; n++) begin
         int r;
         logic pu, po, f, e_o, e_u;
         logic [VLEN-1:0] d;
         r = int'($urandom_range(99, 0));
         d = VLEN'({$urandom(), $urandom()});
         f  = (r < 5);
         pu = !f && (r < 50 || r >= 85);
         po = !f && (r >= 50);
         e_o = 1'b0; e_u = 1'b0;
         if (f) q.delete();
         else if (pu && !po) begin
            if (q.size() == DEPTH) begin e_o = 1'b1; void'(q.pop_front()); end
            q.push_back(d);
         end else if (po && !pu) begin
            if (q.size() == 0) e_u = 1'b1;
            else void'(q.pop_back());
         end else if (pu && po) begin
            if (q.size() == 0) q.push_back(d);
            else q[q.size()-1] = d;
         end
         step(1'b0, f, 1'b0, pu, po, d, '0, e_o, e_u, $sformatf("rnd%0d", n));
         chk_top($sformatf("rnd%0d", n), q.size() != 0,
                 (q.size() != 0) ? q[q.size()-1] : 39'h0, 3'(q.size()));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
